// File: rtl/exec_stage_pkg.sv
// Shared types and constants for the execute stage: opcodes, FSM states,
// the registered control slot and the add/subtract helper.
package exec_stage_pkg;

  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_CMP = 3'b110,
    OP_SLL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_e;

  typedef struct packed {
    logic [3:0]  rd;
    logic        rwrite;
    logic        we;
    logic        select_mem;
    logic        data_input_s;
    logic        data_input_on;
    logic [31:0] store_data;
  } ctrl_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Returns {carry, sum}; subtraction is a + ~b + 1, so carry means no-borrow.
  function automatic logic [32:0] add_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sub);
    logic [31:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
  endfunction

endpackage

// File: rtl/exec_stage_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low 32 bits
// of the unsigned product. The product output is valid in the cycle done=1.
module seq_multiplier
  import exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      acc_step;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(MUL_ITERS - 1));

  always_comb begin
    acc_step = acc_q + (b_q[0] ? a_q : 32'd0);
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      acc_d = acc_step;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      if (last_iter) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && last_iter;
  assign product_o = acc_step;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU with NZCV flags, plus a 33-cycle multiply
// that stalls decode while the sequential multiplier iterates.
module exec_stage
  import exec_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] imm_extend,
  input  logic [2:0]  alu_signal,
  input  logic        opb_select,
  input  logic [3:0]  rd,
  input  logic        rwrite,
  input  logic        we,
  input  logic        select_mem,
  input  logic        data_input_s,
  input  logic        data_input_on,
  input  logic        flush,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [3:0]  out_rd,
  output logic        out_rwrite,
  output logic        out_we,
  output logic        out_select_mem,
  output logic        out_data_input_s,
  output logic        out_data_input_on,
  output logic [3:0]  flags,
  output exec_state_e dbg_state_o
);

  // Handshake: decode holds its register while stall=1; an instruction is
  // consumed at a rising edge with stall=0, and out_valid marks a live slot.

  alu_op_e     op;
  exec_state_e state_q, state_d;
  logic [31:0] opa, opb, opb_eff;
  logic        is_sub;
  logic [32:0] addsub;
  logic [31:0] alu_val;
  flags_t      arith_f;
  ctrl_t       in_ctrl, ctrl_q, ctrl_d, pend_q, pend_d;
  logic [31:0] res_q, res_d;
  logic        valid_q, valid_d;
  flags_t      flags_q, flags_d;
  logic        accept_mul, mul_start, mul_busy, mul_done;
  logic [31:0] mul_product;

  assign op      = alu_op_e'(alu_signal);
  assign opa     = data1;
  assign opb     = opb_select ? imm_extend : data2;
  assign is_sub  = (op != OP_ADD);
  assign opb_eff = is_sub ? ~opb : opb;
  assign addsub  = add_sub(opa, opb, is_sub);

  assign in_ctrl = '{rd: rd, rwrite: rwrite, we: we, select_mem: select_mem,
                     data_input_s: data_input_s, data_input_on: data_input_on,
                     store_data: data2};

  assign accept_mul = (state_q == ST_IDLE) && in_valid && (op == OP_MUL);
  assign mul_start  = accept_mul && !flush;
  assign stall      = !reset && !flush &&
                      (accept_mul || (state_q == ST_MUL && mul_busy && !mul_done));

  always_comb begin
    arith_f.n = addsub[31];
    arith_f.z = (addsub[31:0] == 32'd0);
    arith_f.c = addsub[32];
    arith_f.v = (opa[31] == opb_eff[31]) && (addsub[31] != opa[31]);
  end

  always_comb begin
    unique case (op)
      OP_ADD, OP_SUB: alu_val = addsub[31:0];
      OP_AND:         alu_val = opa & opb;
      OP_OR:          alu_val = opa | opb;
      OP_XOR:         alu_val = opa ^ opb;
      OP_SLL:         alu_val = opa << opb[4:0];
      default:        alu_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (flush || mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot; a multiply's control fields wait in pend_q until it finishes.
  always_comb begin
    res_d   = res_q;
    ctrl_d  = ctrl_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    flags_d = flags_q;
    if (flush) begin
      ctrl_d.rwrite = 1'b0;
      ctrl_d.we     = 1'b0;
    end else if (state_q == ST_MUL) begin
      if (mul_done) begin
        res_d   = mul_product;
        ctrl_d  = pend_q;
        valid_d = 1'b1;
      end else begin
        ctrl_d.rwrite = 1'b0;
        ctrl_d.we     = 1'b0;
      end
    end else if (accept_mul) begin
      pend_d        = in_ctrl;
      ctrl_d.rwrite = 1'b0;
      ctrl_d.we     = 1'b0;
    end else begin
      valid_d       = in_valid;
      ctrl_d        = in_ctrl;
      ctrl_d.rwrite = in_valid && rwrite && (op != OP_CMP);
      ctrl_d.we     = in_valid && we && (op != OP_CMP);
      if (op != OP_CMP) res_d = alu_val;
      if (in_valid && (op == OP_ADD || op == OP_SUB || op == OP_CMP)) flags_d = arith_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      ctrl_q  <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end

  seq_multiplier u_mul (
    .clk       (clk),
    .reset     (reset),
    .abort_i   (flush),
    .start_i   (mul_start),
    .a_i       (opa),
    .b_i       (opb),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign out_valid         = valid_q;
  assign alu_result        = res_q;
  assign store_data        = ctrl_q.store_data;
  assign out_rd            = ctrl_q.rd;
  assign out_rwrite        = ctrl_q.rwrite;
  assign out_we            = ctrl_q.we;
  assign out_select_mem    = ctrl_q.select_mem;
  assign out_data_input_s  = ctrl_q.data_input_s;
  assign out_data_input_on = ctrl_q.data_input_on;
  assign flags             = flags_q;
  assign dbg_state_o       = state_q;

endmodule
